fx2_slave_fifo_ctrl: RTL
========================

FX2_SLAVE_FIFO_CTRL -- requirements
Module: fx2_slave_fifo_ctrl

Interface
REQ-001 Parameter BURST, default 8: maximum words moved per grant before re-arbitration.
REQ-002 Parameter RX_ADDR, default 2'b00: FX2 FIFO address of EP2 (host-to-FPGA).
REQ-003 Parameter TX_ADDR, default 2'b10: FX2 FIFO address of EP6 (FPGA-to-host).
REQ-004 One clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  in  1  system clock; all outputs registered on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 fx2_flaga  in  1  EP2 not-empty, active high.
REQ-008 fx2_flagb  in  1  EP6 not-full, active high.
REQ-009 fx2_db_i  in  16  FX2 data bus input.
REQ-010 fx2_db_o  out  16  FX2 data bus drive value.
REQ-011 fx2_db_oe  out  1  bus drive enable; top level tristates fx2_db when 0.
REQ-012 fx2_slcs_n, fx2_slrd_n, fx2_slwr_n, fx2_sloe_n, fx2_pktend_n  out  1 each  FX2 strobes, active low.
REQ-013 fx2_a  out  2  FX2 FIFO address.
REQ-014 rx_data  out  16, rx_valid  out  1, rx_ready  in  1: host-to-FPGA stream toward the FFT core.
REQ-015 tx_data  in  16, tx_valid  in  1, tx_last  in  1, tx_ready  out  1: FFT-result stream toward host.

Function
REQ-016 FSM states IDLE, RD_SETUP, RD, WR_SETUP, WR, PKTEND.
REQ-017 Request rx_req = fx2_flaga and rx buffer free space; tx_req = tx_valid and fx2_flagb.
REQ-018 IDLE: one request -> its SETUP; both -> round-robin, the direction not served last wins; first grant after reset goes to RX.
REQ-019 RD_SETUP lasts one cycle: fx2_a=RX_ADDR, fx2_slcs_n=0, fx2_sloe_n=0, fx2_db_oe=0.
REQ-020 WR_SETUP lasts one cycle: fx2_a=TX_ADDR, fx2_slcs_n=0, fx2_sloe_n=1, fx2_db_oe=1.
REQ-021 RD: fx2_slrd_n=0 for a cycle only when fx2_flaga=1 and (buffered + in-flight words) < 2.
REQ-022 Read word sampled from fx2_db_i in the cycle after fx2_slrd_n was low; written into a 2-entry rx FIFO.
REQ-023 rx_valid = rx FIFO not empty; rx_data = head word; pop on rx_valid and rx_ready; simultaneous push and pop allowed when full.
REQ-024 RD exits to IDLE after BURST strobes or when fx2_flaga=0; an in-flight word is still captured on exit.
REQ-025 WR: tx_ready = fx2_flagb; on tx_valid and tx_ready the word is registered to fx2_db_o and fx2_slwr_n=0 in the next cycle.
REQ-026 WR exits after BURST words, tx_valid=0, or fx2_flagb=0 -> IDLE; a handshake with tx_last=1 -> PKTEND.
REQ-027 PKTEND: after the last slwr_n pulse, fx2_pktend_n=0 for exactly one cycle with fx2_a=TX_ADDR, then IDLE.
REQ-028 tx_ready=0 outside WR; fx2_slrd_n and fx2_slwr_n never low in the same cycle.
REQ-029 fx2_slcs_n=1 and fx2_db_oe=0 in IDLE; no strobe is issued in a SETUP cycle.
REQ-030 fx2_flagb falling mid-WR: no further handshake; the already registered word is still strobed.

Reset
REQ-031 rst=1: state IDLE; fx2_slcs_n, fx2_slrd_n, fx2_slwr_n, fx2_sloe_n, fx2_pktend_n = 1; fx2_a=2'b00; fx2_db_o=0; fx2_db_oe=0; rx_valid=0; tx_ready=0; rx FIFO emptied; round-robin pointer -> RX.
REQ-032 rst during RD or WR aborts immediately; in-flight read data is discarded and no pktend is issued.

Verification
REQ-033 EP2 model holds 16 words 0x0100..0x010F, rx_ready=1 -> two bursts of 8 slrd_n pulses, rx_data in order, one RD_SETUP per burst.
REQ-034 rx_ready=0 after 2 words -> slrd_n stays high, rx_valid=1 holding 0x0100; release -> 0x0101 next, no word lost or duplicated.
REQ-035 tx stream of 5 words 0xA000..0xA004, tx_last on 0xA004, flagb=1 -> 5 slwr_n pulses at fx2_a=2'b10, then one pktend_n pulse.
REQ-036 Both requesting continuously, BURST=8 -> grants alternate RX,TX,RX; fx2_sloe_n high in every WR cycle.
REQ-037 flagb drops after 3rd tx word -> exactly 3 or 4 strobes (registered word completes), tx_ready=0, resume after flagb=1.
REQ-038 rst pulse mid-RD burst -> all outputs at REQ-031 values the next cycle; rx_valid=0.

Source files
------------

// File: rtl/fx2_slave_fifo_ctrl.sv
// FX2 slave-FIFO controller: arbitrates EP2 reads into a 2-word rx stream and
// tx stream writes into EP6, closing tx_last packets with a PKTEND strobe.
module fx2_slave_fifo_ctrl #(
  parameter int unsigned BURST   = 8,
  parameter logic [1:0]  RX_ADDR = 2'b00,
  parameter logic [1:0]  TX_ADDR = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fx2_flaga,
  input  logic        fx2_flagb,
  input  logic [15:0] fx2_db_i,
  output logic [15:0] fx2_db_o,
  output logic        fx2_db_oe,
  output logic        fx2_slcs_n,
  output logic        fx2_slrd_n,
  output logic        fx2_slwr_n,
  output logic        fx2_sloe_n,
  output logic        fx2_pktend_n,
  output logic [1:0]  fx2_a,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready
);

  localparam int unsigned CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  typedef enum logic [2:0] {IDLE, RD_SETUP, RD, WR_SETUP, WR, PKTEND} state_t;

  state_t        state, ns;
  logic          last_tx;
  logic          cap_q;
  logic          last_seen;
  logic [CW-1:0] rd_cnt, wr_cnt;
  logic [15:0]   mem [2];
  logic          wp, rp;
  logic [1:0]    count;
  logic [2:0]    occ;
  logic          rx_space, rx_req, tx_req, rd_go, hs, push, pop;

  assign rx_valid = (count != 2'd0);
  assign rx_data  = mem[rp];
  assign push     = cap_q;
  assign pop      = rx_valid && rx_ready;

  always_comb begin
    ns       = state;
    occ      = {1'b0, count} + {2'b00, cap_q};
    rx_space = (occ < 3'd2);
    rx_req   = fx2_flaga && rx_space;
    tx_req   = tx_valid && fx2_flagb;
    tx_ready = (state == WR) && fx2_flagb && !last_seen && (wr_cnt < BURST_C);
    hs       = tx_valid && tx_ready;
    case (state)
      IDLE: begin
        if (rx_req && (!tx_req || last_tx)) ns = RD_SETUP;
        else if (tx_req)                    ns = WR_SETUP;
      end
      RD_SETUP: ns = RD;
      // Leave only in a cycle with no strobe on the bus so its word is still read under SLOE.
      RD:       if (fx2_slrd_n && (!fx2_flaga || rd_cnt == BURST_C)) ns = IDLE;
      WR_SETUP: ns = WR;
      // The registered word strobes in the cycle after its handshake, so WR is left one cycle late.
      WR:       if (!hs) ns = last_seen ? PKTEND : IDLE;
      PKTEND:   ns = IDLE;
      default:  ns = IDLE;
    endcase
    // Strobes alternate with idle cycles so fx2_flaga always reflects every completed read.
    rd_go = (state == RD_SETUP || (state == RD && ns == RD)) && fx2_flaga &&
            fx2_slrd_n && rx_space && (rd_cnt < BURST_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      fx2_slcs_n   <= 1'b1;
      fx2_slrd_n   <= 1'b1;
      fx2_slwr_n   <= 1'b1;
      fx2_sloe_n   <= 1'b1;
      fx2_pktend_n <= 1'b1;
      fx2_a        <= 2'b00;
      fx2_db_o     <= '0;
      fx2_db_oe    <= 1'b0;
      last_tx      <= 1'b1;
      cap_q        <= 1'b0;
      last_seen    <= 1'b0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      wp           <= 1'b0;
      rp           <= 1'b0;
      count        <= 2'd0;
    end else begin
      state        <= ns;
      fx2_slcs_n   <= (ns == IDLE);
      fx2_sloe_n   <= !(ns == RD_SETUP || ns == RD);
      fx2_db_oe    <= (ns == WR_SETUP || ns == WR || ns == PKTEND);
      fx2_pktend_n <= (ns != PKTEND);
      fx2_slrd_n   <= !rd_go;
      fx2_slwr_n   <= !hs;
      cap_q        <= !fx2_slrd_n;
      if (ns == RD_SETUP)      fx2_a <= RX_ADDR;
      else if (ns == WR_SETUP) fx2_a <= TX_ADDR;
      if (hs) fx2_db_o <= tx_data;
      if (state == IDLE && ns == RD_SETUP) last_tx <= 1'b0;
      if (state == IDLE && ns == WR_SETUP) last_tx <= 1'b1;
      if (state == IDLE)  rd_cnt <= '0;
      else if (rd_go)     rd_cnt <= rd_cnt + CW'(1);
      if (state == IDLE)  wr_cnt <= '0;
      else if (hs)        wr_cnt <= wr_cnt + CW'(1);
      if (state == IDLE)          last_seen <= 1'b0;
      else if (hs && tx_last)     last_seen <= 1'b1;
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wp] <= fx2_db_i;
  end

endmodule
